// File: rtl/semseg_scan_ctrl.sv
// rtl/semseg_scan_ctrl.sv - Double-buffered N-digit seven-segment scan controller with PWM brightness.
module semseg_scan_ctrl #(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned SLOT_CYCLES    = 1024,
  parameter int unsigned BRIGHT_W       = 4,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [7*DIGITS-1:0] segs_i,
  input  logic [DIGITS-1:0]   dp_i,
  input  logic [DIGITS-1:0]   digit_en_i,
  input  logic                frame_valid_i,
  output logic                frame_ready_o,
  input  logic [BRIGHT_W-1:0] bright_i,
  output logic                frame_start_o,
  output logic [6:0]          seg_o,
  output logic                dp_o,
  output logic [DIGITS-1:0]   an_o
);

  localparam int unsigned SLOT_W = $clog2(SLOT_CYCLES);
  localparam int unsigned DIG_W  = $clog2(DIGITS);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF    = {DIGITS{AN_ACTIVE_LOW}};
  localparam logic [6:0]        SEG_OFF   = {7{SEG_ACTIVE_LOW}};
  localparam logic              DP_OFF    = SEG_ACTIVE_LOW;

  logic [SLOT_W-1:0]         slot_cnt_q, slot_cnt_d;
  logic [DIG_W-1:0]          dig_idx_q, dig_idx_d;
  logic [BRIGHT_W-1:0]       bright_q, bright_d;
  logic [DIGITS-1:0][6:0]    act_segs_q, act_segs_d, pend_segs_q, pend_segs_d;
  logic [DIGITS-1:0]         act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]         act_en_q, act_en_d, pend_en_q, pend_en_d;
  logic                      pend_full_q, pend_full_d;
  logic                      frame_start_q, frame_start_d;
  logic [DIGITS-1:0]         an_q, an_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;

  logic                      slot_wrap, boundary, accept, lit;
  logic [BRIGHT_W-1:0]       phase;
  logic [DIGITS-1:0]         an_onehot;
  logic [6:0]                seg_lit;
  logic                      dp_lit;

  always_comb begin
    slot_wrap = (slot_cnt_q == SLOT_LAST);
    boundary  = slot_wrap && (dig_idx_q == DIG_LAST);
    accept    = frame_valid_i && !pend_full_q;

    slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + SLOT_W'(1);
    dig_idx_d  = dig_idx_q;
    if (slot_wrap) begin
      dig_idx_d = (dig_idx_q == DIG_LAST) ? '0 : dig_idx_q + DIG_W'(1);
    end
    bright_d      = slot_wrap ? bright_i : bright_q;
    frame_start_d = boundary;

    act_segs_d  = act_segs_q;
    act_dp_d    = act_dp_q;
    act_en_d    = act_en_q;
    pend_segs_d = pend_segs_q;
    pend_dp_d   = pend_dp_q;
    pend_en_d   = pend_en_q;
    pend_full_d = pend_full_q;
    if (boundary && pend_full_q) begin
      act_segs_d  = pend_segs_q;
      act_dp_d    = pend_dp_q;
      act_en_d    = pend_en_q;
      pend_full_d = 1'b0;
    end
    // accept only fires with pending empty, so it never collides with the transfer above
    if (accept) begin
      pend_segs_d = segs_i;
      pend_dp_d   = dp_i;
      pend_en_d   = digit_en_i;
      pend_full_d = 1'b1;
    end

    // the top phase can never satisfy phase < bright_q, leaving a dark gap before each digit change
    phase     = slot_cnt_q[SLOT_W-1 -: BRIGHT_W];
    lit       = act_en_q[dig_idx_q] && (phase < bright_q);
    an_onehot = lit ? ({{(DIGITS-1){1'b0}}, 1'b1} << dig_idx_q) : '0;
    seg_lit   = lit ? act_segs_q[dig_idx_q] : 7'h00;
    dp_lit    = lit && act_dp_q[dig_idx_q];
    an_d      = an_onehot ^ AN_OFF;
    seg_d     = seg_lit ^ SEG_OFF;
    dp_d      = dp_lit ^ DP_OFF;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_cnt_q    <= '0;
      dig_idx_q     <= '0;
      bright_q      <= '0;
      act_segs_q    <= '0;
      act_dp_q      <= '0;
      act_en_q      <= '0;
      pend_segs_q   <= '0;
      pend_dp_q     <= '0;
      pend_en_q     <= '0;
      pend_full_q   <= 1'b0;
      frame_start_q <= 1'b0;
      an_q          <= AN_OFF;
      seg_q         <= SEG_OFF;
      dp_q          <= DP_OFF;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      dig_idx_q     <= dig_idx_d;
      bright_q      <= bright_d;
      act_segs_q    <= act_segs_d;
      act_dp_q      <= act_dp_d;
      act_en_q      <= act_en_d;
      pend_segs_q   <= pend_segs_d;
      pend_dp_q     <= pend_dp_d;
      pend_en_q     <= pend_en_d;
      pend_full_q   <= pend_full_d;
      frame_start_q <= frame_start_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign frame_ready_o = !pend_full_q;
  assign frame_start_o = frame_start_q;
  assign an_o          = an_q;
  assign seg_o         = seg_q;
  assign dp_o          = dp_q;

endmodule

// File: tb/tb_semseg_scan_ctrl.sv
// tb/tb_semseg_scan_ctrl.sv - Directed bench for semseg_scan_ctrl with a per-cycle scoreboard.
module tb_semseg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int SLOT   = 16;
  localparam int BW     = 2;
  localparam int TOTAL  = DIGITS * SLOT;
  localparam int PHASE  = SLOT / (1 << BW);

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
    logic       rdy;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [27:0] segs;
  logic [3:0]  dpi;
  logic [3:0]  en;
  logic        valid;
  logic        ready;
  logic [1:0]  bright;
  logic        fs;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;

  exp_t sb_q[$];
  int          m_pos, m_bright;
  logic        m_full;
  logic [27:0] m_act_segs, m_pend_segs;
  logic [3:0]  m_act_dp, m_pend_dp, m_act_en, m_pend_en;

  int win_cnt[DIGITS];
  int win_fs;

  semseg_scan_ctrl #(
    .DIGITS(DIGITS), .SLOT_CYCLES(SLOT), .BRIGHT_W(BW),
    .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .segs_i(segs), .dp_i(dpi), .digit_en_i(en),
    .frame_valid_i(valid), .frame_ready_o(ready), .bright_i(bright),
    .frame_start_o(fs), .seg_o(seg), .dp_o(dp), .an_o(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: one global scan position 0..TOTAL-1, evaluated on the inputs about to be clocked in.
  task automatic model_step();
    exp_t e;
    int   dig, ph;
    logic acc;
    if (rst) begin
      m_pos = 0; m_full = 1'b0; m_bright = 0;
      m_act_segs = '0; m_act_dp = '0; m_act_en = '0;
      e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fs: 1'b0, rdy: 1'b1};
    end else begin
      dig = m_pos / SLOT;
      ph  = (m_pos % SLOT) / PHASE;
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
      if (m_act_en[dig] && (ph < m_bright)) begin
        e.an[dig] = 1'b0;
        e.seg = ~m_act_segs[dig*7 +: 7];
        e.dp  = ~m_act_dp[dig];
      end
      e.fs = (m_pos == TOTAL - 1);
      acc  = valid && !m_full;
      if (m_pos % SLOT == SLOT - 1) m_bright = int'(bright);
      if (m_pos == TOTAL - 1 && m_full) begin
        m_act_segs = m_pend_segs; m_act_dp = m_pend_dp; m_act_en = m_pend_en;
        m_full = 1'b0;
      end
      if (acc) begin
        m_pend_segs = segs; m_pend_dp = dpi; m_pend_en = en;
        m_full = 1'b1;
      end
      m_pos = (m_pos + 1) % TOTAL;
      e.rdy = !m_full;
    end
    sb_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("sb_an", 32'(an), 32'(e.an));
      chk("sb_seg", 32'(seg), 32'(e.seg));
      chk("sb_dp", 32'(dp), 32'(e.dp));
      chk("sb_fs", 32'(fs), 32'(e.fs));
      chk("sb_ready", 32'(ready), 32'(e.rdy));
    end
  endtask

  task automatic offer(input logic [27:0] s, input logic [3:0] d, input logic [3:0] e);
    segs = s; dpi = d; en = e; valid = 1'b1;
  endtask

  task automatic wait_fs(input string tag, output int lit_seen);
    int n;
    lit_seen = 0;
    n = 0;
    while (fs !== 1'b1 && n < 200) begin
      tick();
      if (an !== 4'hF) lit_seen++;
      n++;
    end
    chk(tag, 32'(fs), 32'd1);
  endtask

  task automatic window(input int n);
    for (int k = 0; k < DIGITS; k++) win_cnt[k] = 0;
    win_fs = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      for (int k = 0; k < DIGITS; k++) if (an[k] === 1'b0) win_cnt[k]++;
      if (fs === 1'b1) win_fs++;
    end
  endtask

  localparam logic [27:0] PAT1 = {7'h66, 7'h4F, 7'h5B, 7'h06};
  localparam logic [27:0] PAT_A = {7'h07, 7'h6D, 7'h77, 7'h3F};
  localparam logic [27:0] PAT_B = {7'h39, 7'h5E, 7'h71, 7'h7D};
  localparam logic [27:0] PAT_C = {7'h76, 7'h38, 7'h54, 7'h6F};

  initial begin
    int lit_seen;
    rst = 1'b1; valid = 1'b0; segs = '0; dpi = '0; en = '0; bright = 2'd0;
    tick(); tick();
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_fs", 32'(fs), 32'd0);

    rst = 1'b0; bright = 2'd3;
    repeat (5) tick();
    offer(PAT1, 4'h0, 4'hF);
    tick();
    valid = 1'b0;
    chk("load_ready_low", 32'(ready), 32'd0);
    wait_fs("first_boundary", lit_seen);
    chk("blank_until_boundary", 32'(lit_seen), 32'd0);
    chk("ready_after_boundary", 32'(ready), 32'd1);
    tick();
    chk("first_digit_an", 32'(an), 32'hE);
    chk("first_digit_seg", 32'(seg), 32'(7'h79));
    window(TOTAL);
    for (int k = 0; k < DIGITS; k++) chk("lit12", 32'(win_cnt[k]), 32'd12);
    chk("fs_period", 32'(win_fs), 32'd1);

    bright = 2'd0;
    repeat (SLOT) tick();
    window(TOTAL);
    for (int k = 0; k < DIGITS; k++) chk("lit0", 32'(win_cnt[k]), 32'd0);
    bright = 2'd1;
    repeat (SLOT) tick();
    window(TOTAL);
    for (int k = 0; k < DIGITS; k++) chk("lit4", 32'(win_cnt[k]), 32'd4);

    wait_fs("mid_slot_sync", lit_seen);
    repeat (6) tick();
    bright = 2'd3;
    window(SLOT - 6);
    chk("bright_mid_slot_held", 32'(win_cnt[0]), 32'd0);
    window(SLOT);
    chk("bright_next_slot", 32'(win_cnt[1]), 32'd12);

    wait_fs("a_sync", lit_seen);
    repeat (3) tick();
    offer(PAT_A, 4'b0001, 4'hF);
    tick();
    chk("a_accepted", 32'(ready), 32'd0);
    offer(PAT_B, 4'b0000, 4'hF);
    repeat (3) tick();
    chk("b_ignored_ready", 32'(ready), 32'd0);
    valid = 1'b0;
    wait_fs("a_boundary", lit_seen);
    chk("a_ready_back", 32'(ready), 32'd1);
    tick();
    chk("a_visible_seg", 32'(seg), 32'(7'h40));
    chk("a_visible_dp", 32'(dp), 32'd0);
    offer(PAT_B, 4'b0000, 4'hF);
    tick();
    valid = 1'b0;
    chk("b_accepted", 32'(ready), 32'd0);
    wait_fs("b_boundary", lit_seen);
    tick();
    chk("b_visible_seg", 32'(seg), 32'(7'h02));

    wait_fs("c_sync", lit_seen);
    repeat (TOTAL - 1) tick();
    offer(PAT_C, 4'b0000, 4'hF);
    tick();
    valid = 1'b0;
    chk("c_at_boundary_fs", 32'(fs), 32'd1);
    chk("c_at_boundary_ready", 32'(ready), 32'd0);
    tick();
    chk("c_not_bypassed", 32'(seg), 32'(7'h02));
    wait_fs("c_boundary", lit_seen);
    chk("c_ready_back", 32'(ready), 32'd1);
    tick();
    chk("c_visible_seg", 32'(seg), 32'(7'h10));

    offer(PAT1, 4'b0000, 4'b0101);
    tick();
    valid = 1'b0;
    wait_fs("en_boundary", lit_seen);
    window(TOTAL);
    chk("en_dig0", 32'(win_cnt[0]), 32'd12);
    chk("en_dig1_blank", 32'(win_cnt[1]), 32'd0);
    chk("en_dig2", 32'(win_cnt[2]), 32'd12);
    chk("en_dig3_blank", 32'(win_cnt[3]), 32'd0);
    chk("en_fs_period", 32'(win_fs), 32'd1);

    wait_fs("rst_sync", lit_seen);
    repeat (7) tick();
    offer(PAT_A, 4'hF, 4'hF);
    tick();
    valid = 1'b0;
    chk("pre_rst_pending", 32'(ready), 32'd0);
    rst = 1'b1;
    tick();
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    chk("mid_rst_dp", 32'(dp), 32'd1);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_fs", 32'(fs), 32'd0);
    rst = 1'b0;
    window(TOTAL + 6);
    for (int k = 0; k < DIGITS; k++) chk("pending_lost_blank", 32'(win_cnt[k]), 32'd0);
    chk("post_rst_fs", 32'(win_fs), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
